// File: rtl/seg_accum_display.sv
// seg_accum_display
//   Registered WIDTH-bit adder/accumulator with carry-in, sticky overflow and a
//   valid/done handshake, feeding a DIGITS-wide time-multiplexed hex 7-seg display.
//
//   Optional feature macro: SEG_LEADING_ZERO_BLANK_EN
//     defined   - leading zero digits (never digit 0) show seg=0
//     undefined - every digit shows its hex value
//
//   Ports
//     clk, rst_n     clock, asynchronous active-low reset
//     a, b, cin      operands and carry-in, sampled when valid=1
//     acc_mode       0: result=a+b+cin, 1: result=result+a+cin
//     valid, clr     add request, synchronous clear (clr wins)
//     result, carry  registered sum and carry-out of the last add
//     ovf_sticky     set by any add with carry-out, cleared by clr/reset
//     done           one-cycle pulse after an accepted add
//     seg            active-high segments {g,f,e,d,c,b,a}
//     an             active-low one-hot digit enable, bit 0 = LS digit
module seg_accum_display #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned WIDTH       = 4 * DIGITS,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cin,
  input  logic              acc_mode,
  input  logic              valid,
  input  logic              clr,
  output logic [WIDTH-1:0]  result,
  output logic              carry,
  output logic              ovf_sticky,
  output logic              done,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [WIDTH-1:0]  result_q;
  logic              carry_q, ovf_q, done_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic [WIDTH-1:0]  op2;
  logic [WIDTH:0]    sum;
  logic [DIGITS-1:0] blank_vec;
  logic [3:0]        nibble;
  logic              blank;

  // Add path
  always_comb begin
    op2 = acc_mode ? result_q : b;
    sum = {1'b0, a} + {1'b0, op2} + (WIDTH+1)'(cin);
  end

  // Scan counter / digit index next state
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    idx_d = idx_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Walk from the MS digit down; a digit blanks while everything above it is zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank_vec  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero   = upper_zero & (result_q[4*i +: 4] == 4'h0);
      blank_vec[i] = upper_zero & (i != 0);
    end
  end
`else
  assign blank_vec = '0;
`endif

  // an and seg are both derived from idx_d so they always refer to the same digit.
  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IdxW'(i)) begin
        nibble = result_q[4*i +: 4];
        blank  = blank_vec[i];
      end
    end
    an_d  = ~(DIGITS'(1) << idx_d);
    seg_d = blank ? 7'h00 : hex7(nibble);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      an_q     <= ~DIGITS'(1);
      seg_q    <= 7'h3F;
    end else begin
      done_q <= 1'b0;
      if (clr) begin
        result_q <= '0;
        carry_q  <= 1'b0;
        ovf_q    <= 1'b0;
      end else if (valid) begin
        result_q <= sum[WIDTH-1:0];
        carry_q  <= sum[WIDTH];
        ovf_q    <= ovf_q | sum[WIDTH];
        done_q   <= 1'b1;
      end
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign result     = result_q;
  assign carry      = carry_q;
  assign ovf_sticky = ovf_q;
  assign done       = done_q;
  assign seg        = seg_q;
  assign an         = an_q;

endmodule

// File: tb/tb_seg_accum_display.sv
// Self-checking bench for seg_accum_display (DIGITS=4, REFRESH_DIV=4).
// Expected add results are pushed to a scoreboard queue when an add is driven
// and popped when done pulses.
module tb_seg_accum_display;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned RDIV   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WIDTH-1:0]  a, b;
  logic              cin, acc_mode, valid, clr;
  logic [WIDTH-1:0]  result;
  logic              carry, ovf_sticky, done;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  seg_accum_display #(
    .DIGITS     (DIGITS),
    .WIDTH      (WIDTH),
    .REFRESH_DIV(RDIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .acc_mode  (acc_mode),
    .valid     (valid),
    .clr       (clr),
    .result    (result),
    .carry     (carry),
    .ovf_sticky(ovf_sticky),
    .done      (done),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             ovf;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [15:0] mres     = '0;
  logic        movf     = 1'b0;
  logic [6:0]  hex_tbl[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge and retire any done pulse.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_result", 32'(result), 32'(e.res));
        chk("sb_carry", 32'(carry), 32'(e.cy));
        chk("sb_ovf", 32'(ovf_sticky), 32'(e.ovf));
      end
    end else if (sb.size() != 0) begin
      chk("missing_done", 32'(done), 32'd1);
      void'(sb.pop_front());
    end
  endtask

  task automatic do_add(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input logic mode);
    logic [16:0] s;
    exp_t        e;
    s      = {1'b0, ta} + {1'b0, (mode ? mres : tb_)} + 17'(tc);
    mres   = s[15:0];
    movf   = movf | s[16];
    e.res  = mres;
    e.cy   = s[16];
    e.ovf  = movf;
    sb.push_back(e);
    a = ta; b = tb_; cin = tc; acc_mode = mode; valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  function automatic logic [6:0] exp_seg(input int d, input logic [15:0] v);
    logic [15:0] sh;
    logic [3:0]  nib;
    sh  = v >> (4 * d);
    nib = sh[3:0];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (d != 0 && sh == 16'h0) return 7'h00;
`endif
    return hex_tbl[nib];
  endfunction

  // Wait (bounded) for digit d to be lit, then check its segments.
  task automatic check_digit(input int d, input logic [15:0] v);
    logic [DIGITS-1:0] target;
    int                k;
    target = ~(DIGITS'(1) << d);
    k = 0;
    while (an !== target && k < 4 * RDIV * DIGITS) begin
      step();
      k++;
    end
    chk($sformatf("an_found_d%0d", d), 32'(an), 32'(target));
    chk($sformatf("seg_d%0d", d), 32'(seg), 32'(exp_seg(d, v)));
  endtask

  initial begin
    hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; acc_mode = 1'b0; valid = 1'b0; clr = 1'b0;
    #23;
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_carry", 32'(carry), 32'h0);
    chk("rst_ovf", 32'(ovf_sticky), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_an", 32'(an), 32'hE);
    chk("rst_seg", 32'(seg), 32'h3F);

    // Release just after an edge; edge k after release lands digit (k/4)%4.
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      logic [DIGITS-1:0] ea;
      step();
      ea = ~(DIGITS'(1) << ((k / RDIV) % DIGITS));
      chk($sformatf("scan_an_k%0d", k), 32'(an), 32'(ea));
    end

    // Plain add with carry-in
    do_add(16'h1234, 16'h1111, 1'b1, 1'b0);
    chk("add1_result", 32'(result), 32'h2346);
    step();
    chk("add1_done_once", 32'(done), 32'h0);
    check_digit(0, 16'h2346);
    check_digit(3, 16'h2346);

    // Wrap sets carry and sticky overflow; next add clears carry only
    do_add(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("wrap_carry", 32'(carry), 32'h1);
    do_add(16'h0001, 16'h0001, 1'b0, 1'b0);
    chk("after_wrap_result", 32'(result), 32'h2);
    chk("after_wrap_ovf", 32'(ovf_sticky), 32'h1);

    // Clear, then five back-to-back accumulates of 0x4000
    clr = 1'b1; step(); clr = 1'b0;
    mres = '0; movf = 1'b0;
    chk("clr_ovf", 32'(ovf_sticky), 32'h0);
    begin
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < 5; i++) do_add(16'h4000, 16'h0000, 1'b0, 1'b1);
      step();
      chk("acc_done_pulses", 32'(done_cnt - d0), 32'd5);
      chk("acc_final", 32'(result), 32'h4000);
    end

    // clr beats a simultaneous valid
    do_add(16'hABCD, 16'h0000, 1'b0, 1'b0);
    check_digit(2, 16'hABCD);
    a = 16'h1111; b = 16'h1111; acc_mode = 1'b0; valid = 1'b1; clr = 1'b1;
    step();
    valid = 1'b0; clr = 1'b0;
    mres = '0; movf = 1'b0;
    chk("clrv_result", 32'(result), 32'h0);
    chk("clrv_ovf", 32'(ovf_sticky), 32'h0);
    chk("clrv_done", 32'(done), 32'h0);

    // Leading digits of 0x0050 (blanked only with the optional feature)
    do_add(16'h0050, 16'h0000, 1'b0, 1'b0);
    for (int d = 0; d < DIGITS; d++) check_digit(d, 16'h0050);
    clr = 1'b1; step(); clr = 1'b0;
    mres = '0;
    for (int d = 0; d < DIGITS; d++) check_digit(d, 16'h0000);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
